sync_xfer_fifo: RTL and testbench
=================================

Name: sync_xfer_fifo

Overview:
- Single-clock transfer FIFO for the AHB-to-APB bridge. Each entry holds one transfer: write flag, address and data, written by the AHB-side logic and drained by the APB-side sequencer.
- Generalises the existing FIFO path:
  - parametrised address width and depth;
  - carries the write/read direction bit;
  - adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.

Parameters:
- DSIZE, 32, data width in bits.
- AWIDTH, 32, address width in bits.
- ASIZE, 4, log2 of depth (depth = 2**ASIZE = 16).
- AF_LEVEL, 14, walmost_full asserts when count >= AF_LEVEL (range 1..2**ASIZE).
- AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL (range 0..2**ASIZE-1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- winc  input  1  push request.
- wwrite  input  1  transfer direction to store (1 = APB write).
- waddr  input  AWIDTH  transfer address to store.
- wdata  input  DSIZE  transfer data to store.
- rinc  input  1  pop request.
- err_clr  input  1  synchronous clear of overflow/underflow.
- rwrite  output  1  direction of popped entry.
- raddr  output  AWIDTH  address of popped entry.
- rdata  output  DSIZE  data of popped entry.
- rvalid  output  1  rwrite/raddr/rdata hold a newly popped entry this cycle.
- wfull  output  1  count == 2**ASIZE.
- rempty  output  1  count == 0.
- walmost_full  output  1  count >= AF_LEVEL.
- ralmost_empty  output  1  count <= AE_LEVEL.
- count  output  ASIZE+1  current occupancy, 0..2**ASIZE.
- overflow  output  1  sticky: push attempted while full without a simultaneous accepted pop.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, immediate):
  - Cleared: write/read pointers, count, rwrite, raddr, rdata, rvalid, overflow, underflow, walmost_full.
  - rempty = 1.
  - ralmost_empty = 1 (since 0 <= AE_LEVEL).
  - Storage contents are not reset.
  - Reset mid-operation discards all entries; the first push after deassert lands in slot 0.
- Pointers: ASIZE+1 bits (extra wrap bit); storage is indexed by the low ASIZE bits. Full = pointer low bits equal and wrap bits differ; empty = pointers equal. Each pointer increments modulo 2**(ASIZE+1).
- Pop accepted (re) = rinc & !rempty.
  - rwrite/raddr/rdata are registered from the slot at the read pointer and are valid the cycle after acceptance (1-cycle latency).
  - rvalid = registered re, a 1-cycle pulse per pop.
  - When no pop is accepted, outputs hold their last value and rvalid = 0.
- Push accepted (we) = winc & (!wfull | re).
  - When full, a simultaneous accepted pop frees a slot, so the push is accepted; count is unchanged and the pointers advance together.
- Empty with winc & rinc: the push is accepted, the pop is rejected, underflow sets, count becomes 1; the entry pops on a later cycle.
- Count next value:
  - count + 1 when we & !re;
  - count - 1 when re & !we;
  - otherwise unchanged.
- All flags are registered from next-state count, so they are exact in the same cycle as count (no extra lag).
- Sticky error flags:
  - overflow sets on winc & wfull & !re.
  - underflow sets on rinc & rempty.
  - Both clear on err_clr. If a set condition and err_clr occur in the same cycle, the flag stays set.
  - Rejected operations never modify pointers, count or storage.
- Wrap-around: after 2**ASIZE pushes and pops, pointers wrap and FIFO order is preserved.
- Target size is about 180 lines of RTL.

Test Plan:
- Reset, then push 3 entries {1,0x10,0xA1},{0,0x14,0xB2},{1,0x18,0xC3}; pop 3 back-to-back -> rvalid pulses one cycle after each rinc with the entries in order; count 3->0; rempty = 1 at end.
- Push 16 (ASIZE=4) -> wfull = 1, count = 16, walmost_full from count 14. A 17th push with rinc=0 -> overflow = 1, contents and count unchanged. err_clr -> overflow = 0.
- When full, winc & rinc for 4 cycles -> count stays 16, wfull stays 1, popped data is the oldest 4 entries in order, no overflow.
- When empty, winc & rinc in the same cycle with data 0x55 -> underflow = 1, count = 1, rvalid = 0; the next pop returns 0x55.
- 40 push/pop pairs at random occupancy 0..16 (pointer wrap) -> scoreboard matches order; ralmost_empty = (count <= 2) and walmost_full = (count >= 14) every cycle.
- Assert rst asynchronously mid-burst with count = 9 -> count = 0, rempty = 1, rvalid = 0, flags cleared before the next clk edge; the next push and pop returns the new data.

Source files
------------

// File: rtl/sync_xfer_fifo.sv
// Single-clock transfer FIFO between AHB-side producer and APB-side sequencer.
// Each entry carries {write flag, address, data}; flags are registered from next-state count.
module sync_xfer_fifo #(
   parameter int DSIZE    = 32,
   parameter int AWIDTH   = 32,
   parameter int ASIZE    = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              winc,
   input  logic              wwrite,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DSIZE-1:0]  wdata,
   input  logic              rinc,
   input  logic              err_clr,
   output logic              rwrite,
   output logic [AWIDTH-1:0] raddr,
   output logic [DSIZE-1:0]  rdata,
   output logic              rvalid,
   output logic              wfull,
   output logic              rempty,
   output logic              walmost_full,
   output logic              ralmost_empty,
   output logic [ASIZE:0]    count,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ASIZE;
   localparam int EW    = 1 + AWIDTH + DSIZE;
   localparam logic [ASIZE:0] CNT_ONE  = (ASIZE+1)'(1);
   localparam logic [ASIZE:0] CNT_FULL = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_LEVEL);
   localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_LEVEL);

   logic [EW-1:0] mem_q [DEPTH];

   logic [ASIZE:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
   logic              rwrite_q, rwrite_d, rvalid_q, rvalid_d;
   logic [AWIDTH-1:0] raddr_q, raddr_d;
   logic [DSIZE-1:0]  rdata_q, rdata_d;
   logic              wfull_q, wfull_d, rempty_q, rempty_d;
   logic              walmost_full_q, walmost_full_d;
   logic              ralmost_empty_q, ralmost_empty_d;
   logic              overflow_q, overflow_d, underflow_q, underflow_d;
   logic              re_s, we_s;
   logic [EW-1:0]     rd_entry_s;

   // Next-state logic: acceptance, pointers, occupancy, output capture and flags.
   always_comb begin
      re_s       = rinc & ~rempty_q;
      // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
      we_s       = winc & (~wfull_q | re_s);
      rd_entry_s = mem_q[rptr_q[ASIZE-1:0]];

      if (we_s) begin
         wptr_d = wptr_q + CNT_ONE;
      end else begin
         wptr_d = wptr_q;
      end

      if (re_s) begin
         rptr_d = rptr_q + CNT_ONE;
         {rwrite_d, raddr_d, rdata_d} = rd_entry_s;
      end else begin
         rptr_d   = rptr_q;
         rwrite_d = rwrite_q;
         raddr_d  = raddr_q;
         rdata_d  = rdata_q;
      end
      rvalid_d = re_s;

      case ({we_s, re_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      wfull_d         = (count_d == CNT_FULL);
      rempty_d        = (count_d == {(ASIZE+1){1'b0}});
      walmost_full_d  = (count_d >= AF_CNT);
      ralmost_empty_d = (count_d <= AE_CNT);

      // A new error in the same cycle as err_clr wins.
      overflow_d  = (winc & wfull_q & ~re_s) | (overflow_q & ~err_clr);
      underflow_d = (rinc & rempty_q) | (underflow_q & ~err_clr);
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q          <= {(ASIZE+1){1'b0}};
         rptr_q          <= {(ASIZE+1){1'b0}};
         count_q         <= {(ASIZE+1){1'b0}};
         rwrite_q        <= 1'b0;
         raddr_q         <= {AWIDTH{1'b0}};
         rdata_q         <= {DSIZE{1'b0}};
         rvalid_q        <= 1'b0;
         wfull_q         <= 1'b0;
         rempty_q        <= 1'b1;
         walmost_full_q  <= 1'b0;
         ralmost_empty_q <= 1'b1;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
      end else begin
         wptr_q          <= wptr_d;
         rptr_q          <= rptr_d;
         count_q         <= count_d;
         rwrite_q        <= rwrite_d;
         raddr_q         <= raddr_d;
         rdata_q         <= rdata_d;
         rvalid_q        <= rvalid_d;
         wfull_q         <= wfull_d;
         rempty_q        <= rempty_d;
         walmost_full_q  <= walmost_full_d;
         ralmost_empty_q <= ralmost_empty_d;
         overflow_q      <= overflow_d;
         underflow_q     <= underflow_d;
      end
   end

   // Entry storage, deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_q[wptr_q[ASIZE-1:0]] <= {wwrite, waddr, wdata};
      end
   end

   assign rwrite        = rwrite_q;
   assign raddr         = raddr_q;
   assign rdata         = rdata_q;
   assign rvalid        = rvalid_q;
   assign wfull         = wfull_q;
   assign rempty        = rempty_q;
   assign walmost_full  = walmost_full_q;
   assign ralmost_empty = ralmost_empty_q;
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_xfer_fifo.sv
// Scoreboard bench for sync_xfer_fifo: a queue model of the contents predicts
// each popped entry, occupancy, level flags and sticky errors cycle by cycle.
module tb_sync_xfer_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        winc = 1'b0, wwrite = 1'b0, rinc = 1'b0, err_clr = 1'b0;
   logic [31:0] waddr = 32'h0, wdata = 32'h0;
   logic        rwrite, rvalid, wfull, rempty, walmost_full, ralmost_empty;
   logic        overflow, underflow;
   logic [31:0] raddr, rdata;
   logic [4:0]  count;

   logic [64:0] model_q[$];
   logic [64:0] exp_q[$];
   bit          exp_rv = 1'b0;
   bit          m_ovf = 1'b0, m_udf = 1'b0;
   int          n_cmp = 0, n_mis = 0;

   sync_xfer_fifo dut (
      .clk(clk), .rst(rst), .winc(winc), .wwrite(wwrite), .waddr(waddr),
      .wdata(wdata), .rinc(rinc), .err_clr(err_clr), .rwrite(rwrite),
      .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .wfull(wfull),
      .rempty(rempty), .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [64:0] mk(input logic w, input logic [31:0] a, input logic [31:0] d);
      return {w, a, d};
   endfunction

   // One clock: drive inputs, advance the model, then check outputs after the edge.
   task automatic step(input logic wi, input logic [64:0] ent, input logic ri, input logic ec);
      int sz;
      bit re, we;
      logic [64:0] e;
      winc = wi; {wwrite, waddr, wdata} = ent; rinc = ri; err_clr = ec;
      sz = model_q.size();
      re = ri && (sz > 0);
      we = wi && ((sz < 16) || re);
      m_ovf = (wi && (sz == 16) && !re) || (m_ovf && !ec);
      m_udf = (ri && (sz == 0)) || (m_udf && !ec);
      exp_rv = re;
      if (re) exp_q.push_back(model_q.pop_front());
      if (we) model_q.push_back(ent);
      @(posedge clk);
      #1;
      sz = model_q.size();
      check("rvalid", 96'(rvalid), 96'(exp_rv));
      if (exp_rv) begin
         e = exp_q.pop_front();
         check("rentry", 96'({rwrite, raddr, rdata}), 96'(e));
      end
      check("count", 96'(count), 96'(sz));
      check("wfull", 96'(wfull), 96'(sz == 16));
      check("rempty", 96'(rempty), 96'(sz == 0));
      check("walmost_full", 96'(walmost_full), 96'(sz >= 14));
      check("ralmost_empty", 96'(ralmost_empty), 96'(sz <= 2));
      check("overflow", 96'(overflow), 96'(m_ovf));
      check("underflow", 96'(underflow), 96'(m_udf));
      winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 65'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [64:0] ent;
      repeat (2) @(negedge clk);
      check("rst_count", 96'(count), 96'(0));
      check("rst_rempty", 96'(rempty), 96'(1));
      check("rst_ralmost_empty", 96'(ralmost_empty), 96'(1));
      check("rst_flags", 96'({wfull, walmost_full, rvalid, overflow, underflow}), 96'(0));
      rst = 1'b0;
      @(negedge clk);

      // Basic ordering with three entries.
      step(1'b1, mk(1'b1, 32'h10, 32'hA1), 1'b0, 1'b0);
      step(1'b1, mk(1'b0, 32'h14, 32'hB2), 1'b0, 1'b0);
      step(1'b1, mk(1'b1, 32'h18, 32'hC3), 1'b0, 1'b0);
      repeat (3) step(1'b0, 65'h0, 1'b1, 1'b0);
      idle();

      // Fill, overflow attempt, clear.
      for (int i = 0; i < 16; i++) step(1'b1, mk(i[0], 32'h100 + 32'(i*4), 32'hD000 + 32'(i)), 1'b0, 1'b0);
      step(1'b1, mk(1'b1, 32'hDEAD, 32'hBEEF), 1'b0, 1'b0);
      step(1'b0, 65'h0, 1'b0, 1'b1);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 4; i++) step(1'b1, mk(1'b0, 32'h200 + 32'(i), 32'hE000 + 32'(i)), 1'b1, 1'b0);
      repeat (16) step(1'b0, 65'h0, 1'b1, 1'b0);
      idle();

      // Empty with simultaneous push and pop: pop rejected, underflow.
      step(1'b1, mk(1'b1, 32'h55, 32'h55), 1'b1, 1'b0);
      step(1'b0, 65'h0, 1'b1, 1'b1);
      idle();

      // Random traffic wrapping the pointers.
      for (int i = 0; i < 160; i++) begin
         ent = {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
         step(1'($urandom_range(0, 1)), ent, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      end
      idle();
      while (model_q.size() > 0) step(1'b0, 65'h0, 1'b1, 1'b0);
      idle();

      // Asynchronous reset with nine entries in flight.
      for (int i = 0; i < 9; i++) step(1'b1, mk(1'b1, 32'h300 + 32'(i), 32'hF000 + 32'(i)), 1'b0, 1'b0);
      step(1'b0, 65'h0, 1'b1, 1'b0);
      winc = 1'b1;
      #1 rst = 1'b1;
      #1;
      winc = 1'b0;
      check("arst_count", 96'(count), 96'(0));
      check("arst_rempty", 96'(rempty), 96'(1));
      check("arst_ralmost_empty", 96'(ralmost_empty), 96'(1));
      check("arst_flags", 96'({wfull, walmost_full, rvalid, overflow, underflow}), 96'(0));
      model_q.delete(); exp_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      step(1'b1, mk(1'b0, 32'h400, 32'h1234_5678), 1'b0, 1'b0);
      step(1'b0, 65'h0, 1'b1, 1'b0);
      idle();
      check("scoreboard_drained", 96'(exp_q.size()), 96'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
